btc_nonce_dispatcher: RTL and testbench

- Parametrised multi-core nonce scheduler; the next generation of the single-core miner top.
- Splits the 32-bit nonce space into 2^CHUNK_W-sized chunks and hands them to NUM_CORES hash cores as each core becomes free.
- Collects found/done events from all cores, arbitrates simultaneous finds, and reports a single result to the register block.
- Supports oneshot (stop on first find) and sweep (cover the full space, keep the latest find) modes, plus abort.

---
 rtl/btc_nonce_dispatcher.sv | 191 +++++++++++++++++++
 tb/tb_btc_nonce_dispatcher.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btc_nonce_dispatcher.sv
// Multi-core nonce scheduler: carves the 32-bit nonce space into 2^CHUNK_W chunks,
// feeds them to idle hash cores and merges their find/done events into one result.
module btc_nonce_dispatcher #(
    parameter int NUM_CORES = 4,
    parameter int ID_W      = 2,
    parameter int CHUNK_W   = 24
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      oneshot,
    input  logic                      use_nonce_in,
    input  logic [31:0]               nonce_in,
    output logic [NUM_CORES-1:0]      core_start,
    output logic [NUM_CORES-1:0]      core_abort,
    output logic [NUM_CORES*32-1:0]   core_nonce_base,
    input  logic [NUM_CORES-1:0]      core_done,
    input  logic [NUM_CORES-1:0]      core_found,
    input  logic [NUM_CORES*32-1:0]   core_nonce,
    output logic                      busy,
    output logic                      done,
    output logic                      nonce_found,
    output logic [31:0]               nonce_out,
    output logic [ID_W-1:0]           found_core,
    output logic [7:0]                found_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam int LEFT_W = 33 - CHUNK_W;
    localparam logic [LEFT_W-1:0] TOTAL_CHUNKS = {1'b1, {(LEFT_W-1){1'b0}}};
    localparam logic [LEFT_W-1:0] LEFT_ONE     = {{(LEFT_W-1){1'b0}}, 1'b1};
    localparam logic [31:0]       CHUNK_STEP   = 32'd1 << CHUNK_W;
    localparam logic [31:0]       ALIGN_MASK   = ~(CHUNK_STEP - 32'd1);

    logic [1:0]             r_state;
    logic                   r_oneshot;
    logic [NUM_CORES-1:0]   r_core_busy;
    logic [31:0]            r_next_base;
    logic [LEFT_W-1:0]      r_chunks_left;
    logic [31:0]            r_base [NUM_CORES];
    logic [NUM_CORES-1:0]   r_core_start;
    logic [NUM_CORES-1:0]   r_core_abort;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_nonce_found;
    logic [31:0]            r_nonce_out;
    logic [ID_W-1:0]        r_found_core;
    logic [7:0]             r_found_count;

    logic [31:0]            w_core_nonce [NUM_CORES];
    logic [NUM_CORES-1:0]   w_found_v;
    logic [NUM_CORES-1:0]   w_done_v;
    logic [NUM_CORES-1:0]   w_busy_after;
    logic [NUM_CORES-1:0]   w_idle;
    logic [NUM_CORES-1:0]   w_disp_oh;
    logic [ID_W-1:0]        w_disp_idx;
    logic [ID_W-1:0]        w_win_idx;
    logic [8:0]             w_find_pop;
    logic [8:0]             w_count_sum;
    logic [7:0]             w_count_sat;
    logic                   w_can_dispatch;
    logic                   w_oneshot_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_slices
            assign w_core_nonce[gi]             = core_nonce[32*gi +: 32];
            assign core_nonce_base[32*gi +: 32] = r_base[gi];
        end
    endgenerate

    // Events from cores we never started (or already retired) are dropped here.
    assign w_found_v    = core_found & r_core_busy;
    assign w_done_v     = core_done & r_core_busy;
    assign w_busy_after = r_core_busy & ~w_done_v;
    assign w_idle       = ~r_core_busy;

    always_comb begin
        w_disp_idx = '0;
        w_disp_oh  = '0;
        w_win_idx  = '0;
        w_find_pop = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (w_idle[i]) begin
                w_disp_idx   = ID_W'(i);
                w_disp_oh    = '0;
                w_disp_oh[i] = 1'b1;
            end
            if (w_found_v[i]) begin
                w_win_idx = ID_W'(i);
            end
            w_find_pop = w_find_pop + {8'd0, w_found_v[i]};
        end
    end

    assign w_count_sum    = {1'b0, r_found_count} + w_find_pop;
    assign w_count_sat    = w_count_sum[8] ? 8'hFF : w_count_sum[7:0];
    assign w_can_dispatch = (r_state == S_RUN) && (r_chunks_left != '0) && (|w_idle);
    assign w_oneshot_hit  = r_oneshot && (|w_found_v);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state       <= S_IDLE;
            r_oneshot     <= 1'b0;
            r_core_busy   <= '0;
            r_next_base   <= '0;
            r_chunks_left <= '0;
            r_core_start  <= '0;
            r_core_abort  <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_nonce_found <= 1'b0;
            r_nonce_out   <= '0;
            r_found_core  <= '0;
            r_found_count <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                r_base[i] <= '0;
            end
        end else begin
            r_core_start <= '0;
            r_core_abort <= '0;
            r_done       <= 1'b0;
            if (r_state == S_IDLE) begin
                if (start) begin
                    r_state       <= S_RUN;
                    r_busy        <= 1'b1;
                    r_oneshot     <= oneshot;
                    r_next_base   <= use_nonce_in ? (nonce_in & ALIGN_MASK) : 32'd0;
                    r_chunks_left <= TOTAL_CHUNKS;
                    r_nonce_found <= 1'b0;
                    r_nonce_out   <= '0;
                    r_found_core  <= '0;
                    r_found_count <= '0;
                end
            end else if (abort) begin
                // Abort outranks any find arriving in the same cycle; results are kept.
                r_core_abort <= r_core_busy;
                r_core_busy  <= '0;
                r_state      <= S_IDLE;
                r_busy       <= 1'b0;
            end else begin
                if (|w_found_v) begin
                    r_nonce_found <= 1'b1;
                    r_nonce_out   <= w_core_nonce[w_win_idx];
                    r_found_core  <= w_win_idx;
                    r_found_count <= w_count_sat;
                end
                if (w_oneshot_hit) begin
                    r_core_abort <= w_busy_after;
                    r_core_busy  <= '0;
                    r_done       <= 1'b1;
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                end else if (r_state == S_DRAIN) begin
                    r_core_busy <= w_busy_after;
                    if (w_busy_after == '0) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end else if (w_can_dispatch) begin
                    // A core retiring this cycle is still marked busy, so it waits one cycle.
                    r_core_busy           <= w_busy_after | w_disp_oh;
                    r_core_start          <= w_disp_oh;
                    r_base[w_disp_idx]    <= r_next_base;
                    r_next_base           <= r_next_base + CHUNK_STEP;
                    r_chunks_left         <= r_chunks_left - LEFT_ONE;
                    if (r_chunks_left == LEFT_ONE) begin
                        r_state <= S_DRAIN;
                    end
                end else begin
                    r_core_busy <= w_busy_after;
                end
            end
        end
    end

    assign core_start  = r_core_start;
    assign core_abort  = r_core_abort;
    assign busy        = r_busy;
    assign done        = r_done;
    assign nonce_found = r_nonce_found;
    assign nonce_out   = r_nonce_out;
    assign found_core  = r_found_core;
    assign found_count = r_found_count;

endmodule

// File: tb/tb_btc_nonce_dispatcher.sv
// Randomized bench for btc_nonce_dispatcher: emulated hash cores, a job-level model
// predicting dispatches and job endings, and a monitor that checks them as they appear.
module tb_btc_nonce_dispatcher;

    localparam int NC     = 4;
    localparam int IW     = 2;
    localparam int CW     = 29;
    localparam int NCHUNK = 1 << (32 - CW);
    localparam logic [31:0] STEP = 32'h1 << CW;

    logic              clk = 1'b0;
    logic              arst_n = 1'b0;
    logic              start, abort, oneshot, use_nonce_in;
    logic [31:0]       nonce_in;
    logic [NC-1:0]     core_start, core_abort, core_done, core_found;
    logic [NC*32-1:0]  core_nonce_base, core_nonce;
    logic              busy, done, nonce_found;
    logic [31:0]       nonce_out;
    logic [IW-1:0]     found_core;
    logic [7:0]        found_count;

    btc_nonce_dispatcher #(.NUM_CORES(NC), .ID_W(IW), .CHUNK_W(CW)) dut (
        .clk(clk), .arst_n(arst_n), .start(start), .abort(abort), .oneshot(oneshot),
        .use_nonce_in(use_nonce_in), .nonce_in(nonce_in), .core_start(core_start),
        .core_abort(core_abort), .core_nonce_base(core_nonce_base), .core_done(core_done),
        .core_found(core_found), .core_nonce(core_nonce), .busy(busy), .done(done),
        .nonce_found(nonce_found), .nonce_out(nonce_out), .found_core(found_core),
        .found_count(found_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          cyc;
        int          idx;
        logic [31:0] base;
    } start_ev_t;

    typedef struct {
        int          cyc;
        bit          is_done;
        logic [NC-1:0] mask;
        bit          found;
        logic [31:0] nonce;
        logic [IW-1:0] core;
        logic [7:0]  count;
    } end_ev_t;

    start_ev_t q_start[$];
    end_ev_t   q_end[$];

    // Job-level model state.
    bit          m_run, m_drain, m_oneshot, m_found;
    logic [31:0] m_next, m_nonce;
    int          m_left, m_count, m_core;
    logic [NC-1:0] m_busy;
    int          done_at [NC];

    // Job configuration for the emulated cores.
    int cfg_mode, p_find, p_abort, dur_lo, dur_hi;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_nonce_found"}, nonce_found, 0);
        chk({tag, "_nonce_out"}, nonce_out, 0);
        chk({tag, "_found_core"}, found_core, 0);
        chk({tag, "_found_count"}, found_count, 0);
        chk({tag, "_core_start"}, core_start, 0);
        chk({tag, "_core_abort"}, core_abort, 0);
        chk({tag, "_core_nonce_base"}, core_nonce_base, 0);
    endtask

    // Monitor: compares DUT outputs against predicted events.
    start_ev_t se;
    end_ev_t   ee;
    always @(negedge clk) begin
        if (arst_n) begin
            while (q_start.size() > 0 && q_start[0].cyc < cyc) begin
                checks++; failures++;
                $display("FAIL missed_start: got none, expected core %0d base 0x%08h at cycle %0d",
                         q_start[0].idx, q_start[0].base, q_start[0].cyc);
                void'(q_start.pop_front());
            end
            if (q_start.size() > 0 && q_start[0].cyc == cyc) begin
                logic [NC-1:0] m;
                se = q_start.pop_front();
                m = '0;
                m[se.idx] = 1'b1;
                chk("core_start", core_start, m);
                chk("core_nonce_base", core_nonce_base[se.idx*32 +: 32], se.base);
                chk("busy_running", busy, 1);
                $display("cycle %0d: dispatch core=%0d base=0x%08h", cyc, se.idx, se.base);
            end else if (core_start !== '0) begin
                chk("unexpected_core_start", core_start, 0);
            end

            while (q_end.size() > 0 && q_end[0].cyc < cyc) begin
                checks++; failures++;
                $display("FAIL missed_end: got none, expected end event at cycle %0d", q_end[0].cyc);
                void'(q_end.pop_front());
            end
            if (q_end.size() > 0 && q_end[0].cyc == cyc) begin
                ee = q_end.pop_front();
                chk("core_abort", core_abort, ee.mask);
                chk("done", done, ee.is_done);
                chk("busy_after_end", busy, 0);
                chk("nonce_found", nonce_found, ee.found);
                chk("found_count", found_count, ee.count);
                chk("nonce_out", nonce_out, ee.nonce);
                if (ee.is_done) chk("found_core", found_core, ee.core);
                $display("cycle %0d: job end done=%0d abort_mask=%b found=%0d nonce=0x%08h core=%0d count=%0d",
                         cyc, ee.is_done, ee.mask, ee.found, ee.nonce, ee.core, ee.count);
            end else if (done !== 1'b0 || core_abort !== '0) begin
                chk("unexpected_end", {done, core_abort}, 0);
            end
        end
    end

    task automatic push_end(input bit is_done, input logic [NC-1:0] mask);
        end_ev_t e;
        e.cyc = cyc + 1; e.is_done = is_done; e.mask = mask; e.found = m_found;
        e.nonce = m_nonce; e.core = IW'(m_core); e.count = 8'(m_count);
        q_end.push_back(e);
    endtask

    // One cycle: drive the emulated cores, then advance the model.
    task automatic drive_cycle(input bit do_start);
        logic [NC-1:0] fv, dv, elig;
        bit was_drain;
        int k;
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0; core_done = '0; core_found = '0;
        oneshot = 1'($urandom); use_nonce_in = 1'($urandom); nonce_in = $urandom;
        for (int i = 0; i < NC; i++) core_nonce[i*32 +: 32] = $urandom;
        if (!m_run) begin
            start = do_start;
            abort = ($urandom_range(3) == 0);
            if (do_start && cfg_mode != 2) oneshot = (cfg_mode == 1);
            for (int i = 0; i < NC; i++) begin
                core_done[i]  = ($urandom_range(9) == 0);
                core_found[i] = ($urandom_range(9) == 0);
            end
        end else begin
            abort = ($urandom_range(999) < p_abort);
            start = ($urandom_range(15) == 0);
            for (int i = 0; i < NC; i++) begin
                if (m_busy[i]) begin
                    core_done[i]  = (done_at[i] == cyc);
                    core_found[i] = ($urandom_range(99) < p_find);
                end else begin
                    core_done[i]  = ($urandom_range(9) == 0);
                    core_found[i] = ($urandom_range(9) == 0);
                end
            end
        end

        fv = core_found & m_busy;
        dv = core_done & m_busy;
        if (!m_run) begin
            if (start) begin
                m_run = 1; m_drain = 0; m_oneshot = oneshot;
                m_next = use_nonce_in ? (nonce_in & ~(STEP - 32'd1)) : 32'd0;
                m_left = NCHUNK; m_found = 0; m_nonce = 0; m_core = 0; m_count = 0;
            end
        end else if (abort) begin
            push_end(1'b0, m_busy);
            m_busy = '0; m_run = 0;
        end else begin
            if (fv != '0) begin
                for (int i = NC - 1; i >= 0; i--) if (fv[i]) m_core = i;
                m_nonce = core_nonce[m_core*32 +: 32];
                m_found = 1;
                m_count = m_count + $countones(fv);
                if (m_count > 255) m_count = 255;
            end
            if (m_oneshot && fv != '0) begin
                push_end(1'b1, m_busy & ~dv);
                m_busy = '0; m_run = 0;
            end else begin
                was_drain = m_drain;
                elig = ~m_busy;
                m_busy = m_busy & ~dv;
                if (!was_drain && elig != '0) begin
                    start_ev_t s;
                    k = 0;
                    for (int i = NC - 1; i >= 0; i--) if (elig[i]) k = i;
                    s.cyc = cyc + 1; s.idx = k; s.base = m_next;
                    q_start.push_back(s);
                    m_busy[k] = 1'b1;
                    done_at[k] = cyc + 1 + $urandom_range(dur_hi, dur_lo);
                    m_next = m_next + STEP;
                    m_left--;
                    if (m_left == 0) m_drain = 1;
                end
                if (was_drain && m_busy == '0) begin
                    push_end(1'b1, '0);
                    m_run = 0;
                end
            end
        end
    endtask

    task automatic run_job();
        int guard;
        drive_cycle(1'b1);
        guard = 0;
        while (m_run && guard < 4000) begin
            drive_cycle(1'b0);
            guard++;
        end
        if (m_run) begin
            checks++; failures++;
            $display("FAIL job_timeout: job still running after %0d cycles, expected completion", guard);
            m_run = 0; m_busy = '0;
        end
        repeat ($urandom_range(2)) drive_cycle(1'b0);
    endtask

    initial begin
        #500000;
        failures++;
        $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        start = 0; abort = 0; oneshot = 0; use_nonce_in = 0; nonce_in = '0;
        core_done = '0; core_found = '0; core_nonce = '0;
        m_run = 0; m_drain = 0; m_busy = '0; m_oneshot = 0;
        m_found = 0; m_nonce = '0; m_core = 0; m_count = 0; m_next = '0; m_left = 0;
        for (int i = 0; i < NC; i++) done_at[i] = -1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        arst_n = 1'b1;

        for (int j = 0; j < 36; j++) begin
            cfg_mode = j % 3;
            p_find   = (j % 4 == 0) ? 0 : $urandom_range(15, 1);
            p_abort  = (j % 5 == 4) ? 40 : 0;
            dur_lo   = 1;
            dur_hi   = 8;
            run_job();
        end

        // Long sweep with constant finds drives found_count into saturation.
        cfg_mode = 0; p_find = 100; p_abort = 0; dur_lo = 40; dur_hi = 50;
        run_job();

        // Asynchronous reset in the middle of a sweep.
        cfg_mode = 0; p_find = 0; p_abort = 0; dur_lo = 5; dur_hi = 8;
        drive_cycle(1'b1);
        repeat (12) drive_cycle(1'b0);
        @(posedge clk);
        #1;
        q_start.delete();
        q_end.delete();
        arst_n = 1'b0;
        start = 0; abort = 0; core_done = '0; core_found = '0;
        m_run = 0; m_drain = 0; m_busy = '0;
        #2;
        check_reset_outputs("mid_reset");
        @(posedge clk);
        #1;
        check_reset_outputs("mid_reset_hold");
        arst_n = 1'b1;

        cfg_mode = 1; p_find = 10; p_abort = 0; dur_lo = 1; dur_hi = 8;
        run_job();
        repeat (4) drive_cycle(1'b0);
        @(negedge clk);
        #1;
        chk("start_queue_empty", q_start.size(), 0);
        chk("end_queue_empty", q_end.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
